// File: rtl/lmsm_sequencer.sv
// Load-multiple / store-multiple sequencer for the MEM stage.
// It issues one memory transfer per selected register, lowest register first.
module lmsm_sequencer #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    localparam int IDX_W = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              is_store,
    input  logic [NREG-1:0]   reg_mask,
    input  logic [DATA_W-1:0] base_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [IDX_W-1:0]  rf_raddr,
    output logic              rf_we,
    output logic [IDX_W-1:0]  rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_XFER,
        S_DONE
    } state_e;

    state_e            state_q;
    logic              dir_q;
    logic [NREG-1:0]   rem_q;
    logic [DATA_W-1:0] addr_q;

    logic [IDX_W-1:0]  curIdx;
    logic [NREG-1:0]   rem_d;

    // Lowest set bit wins, so registers go out in ascending order.
    always_comb begin
        curIdx = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (rem_q[i]) begin
                curIdx = IDX_W'(i);
            end
        end
    end

    assign rem_d = rem_q & ~(NREG'(1) << curIdx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            dir_q   <= 1'b0;
            rem_q   <= '0;
            addr_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        dir_q   <= is_store;
                        rem_q   <= reg_mask;
                        addr_q  <= base_addr;
                        state_q <= (reg_mask != '0) ? S_XFER : S_DONE;
                    end
                end
                S_XFER: begin
                    rem_q   <= rem_d;
                    addr_q  <= addr_q + DATA_W'(1);
                    state_q <= (rem_d == '0) ? S_DONE : S_XFER;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs depend only on registered state, plus the read data passed through during a transfer.
    always_comb begin
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        rf_raddr  = '0;
        rf_we     = 1'b0;
        rf_waddr  = '0;
        rf_wdata  = '0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            S_XFER: begin
                busy     = 1'b1;
                mem_addr = addr_q;
                if (dir_q) begin
                    mem_wr    = 1'b1;
                    rf_raddr  = curIdx;
                    mem_wdata = rf_rdata;
                end else begin
                    mem_rd   = 1'b1;
                    rf_we    = 1'b1;
                    rf_waddr = curIdx;
                    rf_wdata = mem_rdata;
                end
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Directed bench for lmsm_sequencer with a behavioural data memory and register file.
// Expected values are hand-computed from the preloaded contents.
module tb_lmsm_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        is_store;
    logic [7:0]  reg_mask;
    logic [15:0] base_addr;
    logic [15:0] mem_rdata;
    logic [15:0] rf_rdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [2:0]  rf_raddr;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        busy;
    logic        done;

    int assertCount;
    int failCount;
    int doneCnt;

    logic [15:0] mem [0:65535] = '{default: 16'h0000};
    logic [15:0] rf  [0:7]     = '{default: 16'h0000};

    logic        tbMemWe;
    logic [15:0] tbMemAddr;
    logic [15:0] tbMemData;
    logic        tbRfWe;
    logic [2:0]  tbRfAddr;
    logic [15:0] tbRfData;

    lmsm_sequencer #(.DATA_W(16), .NREG(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_store  (is_store),
        .reg_mask  (reg_mask),
        .base_addr (base_addr),
        .mem_rdata (mem_rdata),
        .rf_rdata  (rf_rdata),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .rf_raddr  (rf_raddr),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    assign rf_rdata  = rf[rf_raddr];

    // Memory and register file commit on the rising edge; the bench preload port shares the same process.
    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_wdata;
        else if (tbMemWe) mem[tbMemAddr] <= tbMemData;
        if (rf_we) rf[rf_waddr] <= rf_wdata;
        else if (tbRfWe) rf[tbRfAddr] <= tbRfData;
    end

    function automatic logic [15:0] rfInit(input int i);
        return 16'h1000 + 16'(i) * 16'h0111;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assertCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput(tag, 64'({mem_rd, mem_wr, mem_addr, mem_wdata, rf_raddr, rf_we,
                              rf_waddr, rf_wdata, busy, done}), 64'h0);
    endtask

    task automatic preloadRf();
        for (int i = 0; i < 8; i++) begin
            tbRfWe   = 1'b1;
            tbRfAddr = 3'(i);
            tbRfData = rfInit(i);
            @(negedge clk);
        end
        tbRfWe = 1'b0;
    endtask

    task automatic preloadMem(input logic [15:0] a, input logic [15:0] d);
        tbMemWe   = 1'b1;
        tbMemAddr = a;
        tbMemData = d;
        @(negedge clk);
        tbMemWe = 1'b0;
    endtask

    // Pulses start for one cycle; returns at the falling edge of the first cycle after acceptance.
    task automatic applyStimulus(input logic st, input logic [7:0] mask, input logic [15:0] base);
        start     = 1'b1;
        is_store  = st;
        reg_mask  = mask;
        base_addr = base;
        @(negedge clk);
        start     = 1'b0;
        is_store  = 1'b0;
        reg_mask  = 8'h00;
        base_addr = 16'h0000;
    endtask

    initial begin
        logic [2:0]  lmIdx [0:2];
        logic [15:0] lmVal [0:2];
        assertCount = 0;
        failCount   = 0;
        start = 1'b0; is_store = 1'b0; reg_mask = 8'h00; base_addr = 16'h0000;
        tbMemWe = 1'b0; tbMemAddr = 16'h0; tbMemData = 16'h0;
        tbRfWe = 1'b0; tbRfAddr = 3'h0; tbRfData = 16'h0;
        lmIdx = '{3'd0, 3'd2, 3'd7};
        lmVal = '{16'hAAAA, 16'hBBBB, 16'hCCCC};

        rst_n = 1'b0;
        #1;
        checkAllZero("reset_outputs");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkAllZero("idle_after_reset");
        preloadRf();

        $display("[TB] SM all registers");
        applyStimulus(1'b1, 8'hFF, 16'h0100);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("sm_wr_%0d", i), 64'(mem_wr), 64'h1);
            checkOutput($sformatf("sm_addr_%0d", i), 64'(mem_addr), 64'(16'h0100 + 16'(i)));
            checkOutput($sformatf("sm_raddr_%0d", i), 64'(rf_raddr), 64'(i));
            checkOutput($sformatf("sm_wdata_%0d", i), 64'(mem_wdata), 64'(rfInit(i)));
            checkOutput($sformatf("sm_busy_%0d", i), 64'({busy, done, mem_rd, rf_we}), 64'b1000);
            @(negedge clk);
        end
        checkOutput("sm_done", 64'({done, busy, mem_wr}), 64'b100);
        @(negedge clk);
        checkOutput("sm_idle", 64'({done, busy}), 64'b00);
        for (int i = 0; i < 8; i++)
            checkOutput($sformatf("sm_mem_%0d", i), 64'(mem[16'h0100 + 16'(i)]), 64'(rfInit(i)));
        checkOutput("sm_mem_beyond", 64'(mem[16'h0108]), 64'h0);

        $display("[TB] LM sparse mask");
        preloadMem(16'h0020, 16'hAAAA);
        preloadMem(16'h0021, 16'hBBBB);
        preloadMem(16'h0022, 16'hCCCC);
        applyStimulus(1'b0, 8'h85, 16'h0020);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("lm_strobes_%0d", i), 64'({mem_rd, rf_we, mem_wr, busy, done}), 64'b11010);
            checkOutput($sformatf("lm_addr_%0d", i), 64'(mem_addr), 64'(16'h0020 + 16'(i)));
            checkOutput($sformatf("lm_waddr_%0d", i), 64'(rf_waddr), 64'(lmIdx[i]));
            checkOutput($sformatf("lm_wdata_%0d", i), 64'(rf_wdata), 64'(lmVal[i]));
            @(negedge clk);
        end
        checkOutput("lm_done", 64'({done, busy, rf_we, mem_rd}), 64'b1000);
        @(negedge clk);
        checkOutput("lm_idle", 64'({done, busy}), 64'b00);
        checkOutput("lm_r0", 64'(rf[0]), 64'hAAAA);
        checkOutput("lm_r1", 64'(rf[1]), 64'(rfInit(1)));
        checkOutput("lm_r2", 64'(rf[2]), 64'hBBBB);
        checkOutput("lm_r7", 64'(rf[7]), 64'hCCCC);

        $display("[TB] empty mask");
        applyStimulus(1'b1, 8'h00, 16'h0400);
        checkOutput("empty_done", 64'({done, busy, mem_rd, mem_wr, rf_we}), 64'b10000);
        @(negedge clk);
        checkAllZero("empty_idle");

        $display("[TB] address wrap");
        preloadRf();
        applyStimulus(1'b1, 8'h03, 16'hFFFF);
        checkOutput("wrap_addr_0", 64'(mem_addr), 64'hFFFF);
        @(negedge clk);
        checkOutput("wrap_addr_1", 64'(mem_addr), 64'h0000);
        checkOutput("wrap_raddr_1", 64'(rf_raddr), 64'h1);
        @(negedge clk);
        checkOutput("wrap_done", 64'(done), 64'h1);
        @(negedge clk);
        checkOutput("wrap_mem_ffff", 64'(mem[16'hFFFF]), 64'(rfInit(0)));
        checkOutput("wrap_mem_0000", 64'(mem[16'h0000]), 64'(rfInit(1)));

        $display("[TB] reset mid-sequence");
        applyStimulus(1'b1, 8'hFF, 16'h0200);
        repeat (2) @(negedge clk);
        checkOutput("rst_third_xfer", 64'({mem_wr, mem_addr}), 64'({1'b1, 16'h0202}));
        rst_n = 1'b0;
        #1;
        checkAllZero("rst_mid_outputs");
        @(negedge clk);
        checkAllZero("rst_held_outputs");
        rst_n = 1'b1;
        @(negedge clk);
        checkAllZero("rst_release_idle");
        @(negedge clk);
        checkAllZero("rst_release_idle2");
        checkOutput("rst_mem_0", 64'(mem[16'h0200]), 64'(rfInit(0)));
        checkOutput("rst_mem_1", 64'(mem[16'h0201]), 64'(rfInit(1)));
        checkOutput("rst_mem_2", 64'(mem[16'h0202]), 64'h0);

        $display("[TB] start ignored during transfer");
        doneCnt = 0;
        applyStimulus(1'b1, 8'h0F, 16'h0300);
        for (int i = 0; i < 4; i++) begin
            start = 1'b0; is_store = 1'b0; reg_mask = 8'h00; base_addr = 16'h0000;
            checkOutput($sformatf("ign_wr_%0d", i), 64'({mem_wr, mem_rd, busy}), 64'b101);
            checkOutput($sformatf("ign_addr_%0d", i), 64'(mem_addr), 64'(16'h0300 + 16'(i)));
            checkOutput($sformatf("ign_raddr_%0d", i), 64'(rf_raddr), 64'(i));
            if (done) doneCnt++;
            if (i == 1) begin
                start = 1'b1; is_store = 1'b0; reg_mask = 8'hF0; base_addr = 16'h0500;
            end
            @(negedge clk);
        end
        checkOutput("ign_done", 64'({done, busy}), 64'b10);
        for (int i = 0; i < 6; i++) begin
            if (done) doneCnt++;
            checkOutput($sformatf("ign_no_strobe_%0d", i), 64'({mem_rd, mem_wr, rf_we}), 64'b000);
            @(negedge clk);
        end
        checkOutput("ign_done_count", 64'(doneCnt), 64'd1);
        checkOutput("ign_mem_500", 64'(mem[16'h0500]), 64'h0);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
